// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller: operand-mux select codes,
// controller FSM encodings and the in-flight destination scoreboard entry.
package hazard_forward_ctrl_pkg;

  localparam int SB_ADDR_W = 5;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXMEM  = 2'b01;
  localparam logic [1:0] FWD_MEMWB  = 2'b10;
  localparam logic [1:0] FWD_WBHOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] dst;
    logic                 load;
  } sb_entry_t;

  function automatic logic sb_hit(input sb_entry_t e, input logic [SB_ADDR_W-1:0] r);
    return e.valid && (e.dst == r);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority compare of one source register against the EX/MEM/WB producers;
// the nearest producer wins and register 0 never forwards.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
(
  input  logic [SB_ADDR_W-1:0] src_i,
  input  sb_entry_t            ex_i,
  input  sb_entry_t            mem_i,
  input  sb_entry_t            wb_i,
  output logic [1:0]           sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (src_i != '0) begin
      if (sb_hit(ex_i, src_i))       sel_o = FWD_EXMEM;
      else if (sb_hit(mem_i, src_i)) sel_o = FWD_MEMWB;
      else if (sb_hit(wb_i, src_i))  sel_o = FWD_WBHOLD;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: tracks in-flight destinations,
// registers EX operand-mux selects, and issues load-use stalls and taken-branch flushes.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = SB_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRs,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Dst,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  EX_BranchTaken,
  output logic                  PC_Write,
  output logic                  IFID_Write,
  output logic                  IFID_Flush,
  output logic                  IDEX_Bubble,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic [CNT_W-1:0]      StallCount,
  output logic [CNT_W-1:0]      FlushCount,
  output logic [1:0]            Dbg_State
);

  hz_state_e        state_q, state_d;
  sb_entry_t        ex_q, mem_q, wb_q, id_ent;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use;

  fwd_select u_fwd_a (.src_i(ID_Rs), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_a));
  fwd_select u_fwd_b (.src_i(ID_Rt), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q), .sel_o(sel_b));

  assign load_use = ID_Valid && ex_q.valid && ex_q.load && (ex_q.dst != '0) &&
                    ((ID_UsesRs && (ID_Rs == ex_q.dst)) || (ID_UsesRt && (ID_Rt == ex_q.dst)));

  // Hazard outputs follow the next-state decision so the stall/flush acts this cycle;
  // Reset forces the idle values even though it is sampled combinationally here.
  always_comb begin
    state_d     = ST_RUN;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    if (!Reset && (state_q == ST_RUN)) begin
      if (EX_BranchTaken) state_d = ST_FLUSH;
      else if (load_use)  state_d = ST_STALL;
    end
    case (state_d)
      ST_STALL: begin
        PC_Write    = 1'b0;
        IFID_Write  = 1'b0;
        IDEX_Bubble = 1'b1;
      end
      ST_FLUSH: begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    id_ent.valid = ID_Valid && ID_RegWrite && !IDEX_Bubble;
    id_ent.dst   = ID_Dst;
    id_ent.load  = ID_MemRead;
    fwd_a_d      = (IDEX_Bubble || !ID_Valid) ? FWD_RF : sel_a;
    fwd_b_d      = (IDEX_Bubble || !ID_Valid) ? FWD_RF : sel_b;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_d == ST_STALL) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((state_d == ST_FLUSH) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= id_ent;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ForwardA   = fwd_a_q;
  assign ForwardB   = fwd_b_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed pipeline scenarios then random instruction
// streams, checked against a history-list model of the in-flight instructions.
module tb_hazard_forward_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ID_Valid, ID_UsesRs, ID_UsesRt, ID_RegWrite, ID_MemRead, EX_BranchTaken;
  logic [4:0]  ID_Rs, ID_Rt, ID_Dst;
  logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble;
  logic [1:0]  ForwardA, ForwardB, Dbg_State;
  logic [31:0] StallCount, FlushCount;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Dst(ID_Dst),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .StallCount(StallCount), .FlushCount(FlushCount), .Dbg_State(Dbg_State)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: hist[0] is the instruction now in EX, hist[1] MEM, hist[2] WB
  typedef struct { bit valid; int dst; bit load; } m_ent_t;
  m_ent_t     hist[$];
  bit         m_blocked;
  int         m_stall, m_flush;
  logic [3:0] exp_q[$];

  task automatic model_reset();
    m_ent_t e;
    e.valid = 0; e.dst = 0; e.load = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(e);
    m_blocked = 0;
    m_stall   = 0;
    m_flush   = 0;
    exp_q.delete();
  endtask

  function automatic int nearest(input int r);
    if (r == 0) return 0;
    for (int i = 0; i < hist.size(); i++)
      if (hist[i].valid && hist[i].dst == r) return i + 1;
    return 0;
  endfunction

  task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input int dst, input bit rw, input bit mr, input bit br);
    ID_Valid = v; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UsesRs = urs; ID_UsesRt = urt;
    ID_Dst = 5'(dst); ID_RegWrite = rw; ID_MemRead = mr; EX_BranchTaken = br;
  endtask

  // One pipeline cycle; entered at posedge+1, returns at the next posedge+1.
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int dst, input bit rw, input bit mr, input bit br);
    bit fl, lu, st;
    logic [1:0] ea, eb;
    logic [3:0] ex_pair;
    m_ent_t e;
    drive(v, rs, rt, urs, urt, dst, rw, mr, br);
    #2;
    fl = !m_blocked && br;
    lu = v && hist[0].valid && hist[0].load && hist[0].dst != 0 &&
         ((urs && rs == hist[0].dst) || (urt && rt == hist[0].dst));
    st = !m_blocked && !fl && lu;
    check_eq("pc_write",    32'(PC_Write),    32'(!st));
    check_eq("ifid_write",  32'(IFID_Write),  32'(!st));
    check_eq("ifid_flush",  32'(IFID_Flush),  32'(fl));
    check_eq("idex_bubble", 32'(IDEX_Bubble), 32'(fl || st));
    ea = (fl || st || !v) ? 2'b00 : 2'(nearest(rs));
    eb = (fl || st || !v) ? 2'b00 : 2'(nearest(rt));
    exp_q.push_back({ea, eb});
    e.valid = v && rw && !(fl || st); e.dst = dst; e.load = mr;
    hist.push_front(e);
    void'(hist.pop_back());
    m_blocked = fl || st;
    if (st) m_stall++;
    if (fl) m_flush++;
    @(posedge Clk); #1;
    ex_pair = exp_q.pop_front();
    check_eq("forward_a",   32'(ForwardA),  32'(ex_pair[3:2]));
    check_eq("forward_b",   32'(ForwardB),  32'(ex_pair[1:0]));
    check_eq("stall_count", StallCount,     32'(m_stall));
    check_eq("flush_count", FlushCount,     32'(m_flush));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_pc_write"},    32'(PC_Write),    32'd1);
    check_eq({tag, "_ifid_write"},  32'(IFID_Write),  32'd1);
    check_eq({tag, "_ifid_flush"},  32'(IFID_Flush),  32'd0);
    check_eq({tag, "_idex_bubble"}, 32'(IDEX_Bubble), 32'd0);
    check_eq({tag, "_forward_a"},   32'(ForwardA),    32'd0);
    check_eq({tag, "_forward_b"},   32'(ForwardB),    32'd0);
    check_eq({tag, "_stall_count"}, StallCount,       32'd0);
    check_eq({tag, "_flush_count"}, FlushCount,       32'd0);
  endtask

  initial begin
    // reset, with a branch request that must be ignored while Reset is high
    Reset = 1'b1;
    drive(1, 1, 2, 1, 1, 3, 1, 1, 1);
    model_reset();
    @(posedge Clk); #1;
    check_idle("reset");
    @(posedge Clk); #1;
    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // add $3 in EX, next instruction reads $3 as Rs
    step(1, 1, 2, 1, 1, 3, 1, 0, 0);
    step(1, 3, 7, 1, 1, 8, 1, 0, 0);
    check_eq("add_fwd_a", 32'(ForwardA), 32'd1);

    // lw $5 then a reader of $5 as Rt: one stall, then MEM/WB forward
    step(1, 0, 0, 1, 0, 5, 1, 1, 0);
    step(1, 1, 5, 1, 1, 9, 1, 0, 0);
    step(1, 1, 5, 1, 1, 9, 1, 0, 0);
    check_eq("lw_fwd_b", 32'(ForwardB), 32'd2);
    check_eq("lw_stall_count", StallCount, 32'd1);

    // $4 written in EX, MEM and WB: nearest wins; then WB-only producer
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 4, 0, 1, 0, 13, 0, 0, 0);
    check_eq("r4_nearest_fwd_a", 32'(ForwardA), 32'd1);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step(1, 0, 0, 0, 0, 10, 1, 0, 0);
    step(1, 0, 0, 0, 0, 11, 1, 0, 0);
    step(1, 4, 0, 1, 0, 13, 0, 0, 0);
    check_eq("r4_wbhold_fwd_a", 32'(ForwardA), 32'd3);

    // load into $0 followed by a reader of $0: no stall, no forward
    step(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 14, 1, 0, 0);
    check_eq("r0_fwd_a", 32'(ForwardA), 32'd0);
    check_eq("r0_no_stall", StallCount, 32'd1);

    // taken branch together with a load-use: flush wins
    step(1, 0, 0, 0, 0, 6, 1, 1, 0);
    step(1, 6, 0, 1, 0, 15, 1, 0, 1);
    check_eq("br_stall_count", StallCount, 32'd1);
    check_eq("br_flush_count", FlushCount, 32'd1);
    step(1, 6, 0, 1, 0, 15, 1, 0, 0);

    // reset while the stall outputs are active, with a live forward select
    step(1, 0, 0, 0, 0, 12, 1, 0, 0);
    step(1, 12, 0, 1, 0, 7, 1, 1, 0);
    check_eq("pre_rst_fwd_a", 32'(ForwardA), 32'd1);
    drive(1, 7, 0, 1, 0, 16, 1, 0, 0);
    #2;
    check_eq("pre_rst_bubble", 32'(IDEX_Bubble), 32'd1);
    Reset = 1'b1;
    #1;
    check_idle("mid_stall_reset");
    @(posedge Clk); #1;
    check_idle("held_reset");
    Reset = 1'b0;
    model_reset();

    // random instruction streams over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 7)),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
